// File: rtl/block_collision_scan.sv
// rtl/block_collision_scan.sv - sequential 4x4 piece vs playfield collision scanner
module block_collision_scan #(
    parameter int FIELD_W    = 20,
    parameter int FIELD_H    = 20,
    parameter int EARLY_EXIT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [15:0]                block,
    input  logic [FIELD_W*FIELD_H-1:0] field,
    input  logic [4:0]                 block_pos_x,
    input  logic [4:0]                 block_pos_y,
    output logic                       busy,
    output logic                       done,
    output logic                       collide,
    output logic [3:0]                 hit_cell,
    output logic [1:0]                 b_x,
    output logic [1:0]                 b_y,
    output logic [3:0]                 block_index,
    output logic [8:0]                 field_index
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                     r_state;
    logic [3:0]                 r_cnt;
    logic [15:0]                r_block;
    logic [FIELD_W*FIELD_H-1:0] r_field;
    logic [4:0]                 r_pos_x;
    logic [4:0]                 r_pos_y;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_collide;
    logic [3:0]                 r_hit_cell;

    logic       w_scan;
    logic [5:0] w_cx;
    logic [5:0] w_cy;
    logic       w_oob;
    logic [8:0] w_lin;
    logic [8:0] w_field_index;
    logic       w_cell_hit;

    // Six-bit coordinates so origin 31 + offset 3 cannot wrap back into range.
    assign w_scan        = (r_state == S_SCAN);
    assign w_cx          = {1'b0, r_pos_x} + {4'b0, r_cnt[1:0]};
    assign w_cy          = {1'b0, r_pos_y} + {4'b0, r_cnt[3:2]};
    assign w_oob         = (w_cx >= 6'(FIELD_W)) || (w_cy >= 6'(FIELD_H));
    assign w_lin         = 9'(w_cy) * 9'(FIELD_W) + 9'(w_cx);
    assign w_field_index = w_oob ? 9'd0 : w_lin;
    assign w_cell_hit    = r_block[r_cnt] & (w_oob | r_field[w_field_index]);

    assign busy        = r_busy;
    assign done        = r_done;
    assign collide     = r_collide;
    assign hit_cell    = r_hit_cell;
    assign b_x         = w_scan ? r_cnt[1:0] : 2'd0;
    assign b_y         = w_scan ? r_cnt[3:2] : 2'd0;
    assign block_index = w_scan ? r_cnt : 4'd0;
    assign field_index = w_scan ? w_field_index : 9'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_block    <= '0;
            r_field    <= '0;
            r_pos_x    <= 5'd0;
            r_pos_y    <= 5'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_collide  <= 1'b0;
            r_hit_cell <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_block    <= block;
                        r_field    <= field;
                        r_pos_x    <= block_pos_x;
                        r_pos_y    <= block_pos_y;
                        r_cnt      <= 4'd0;
                        r_collide  <= 1'b0;
                        r_hit_cell <= 4'd0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // Only the first colliding cell is reported when scanning all cells.
                    if (w_cell_hit && !r_collide) begin
                        r_collide  <= 1'b1;
                        r_hit_cell <= r_cnt;
                    end
                    if (((EARLY_EXIT != 0) && w_cell_hit) || (r_cnt == 4'd15)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_collision_scan.sv
// tb/tb_block_collision_scan.sv - bench for block_collision_scan, early-exit and full-scan builds side by side
module tb_block_collision_scan;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [15:0]  blk;
    logic [399:0] fld;
    logic [4:0]   px;
    logic [4:0]   py;

    logic       e_busy, e_done, e_collide;
    logic [3:0] e_hit, e_bi;
    logic [1:0] e_bx, e_by;
    logic [8:0] e_fi;
    logic       f_busy, f_done, f_collide;
    logic [3:0] f_hit, f_bi;
    logic [1:0] f_bx, f_by;
    logic [8:0] f_fi;

    int total = 0;
    int bad   = 0;

    block_collision_scan #(.FIELD_W(20), .FIELD_H(20), .EARLY_EXIT(1)) u_dut_e (
        .clk(clk), .rst_n(rst_n), .start(start), .block(blk), .field(fld),
        .block_pos_x(px), .block_pos_y(py), .busy(e_busy), .done(e_done),
        .collide(e_collide), .hit_cell(e_hit), .b_x(e_bx), .b_y(e_by),
        .block_index(e_bi), .field_index(e_fi)
    );

    block_collision_scan #(.FIELD_W(20), .FIELD_H(20), .EARLY_EXIT(0)) u_dut_f (
        .clk(clk), .rst_n(rst_n), .start(start), .block(blk), .field(fld),
        .block_pos_x(px), .block_pos_y(py), .busy(f_busy), .done(f_done),
        .collide(f_collide), .hit_cell(f_hit), .b_x(f_bx), .b_y(f_by),
        .block_index(f_bi), .field_index(f_fi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [399:0] rand_field(input int density);
        logic [399:0] v;
        for (int i = 0; i < 400; i++) v[i] = ($urandom_range(0, 99) < density);
        return v;
    endfunction

    // Reference: walk the piece cells in row-major order on a 20x20 board.
    function automatic void model(input logic [15:0] b, input logic [399:0] f,
                                  input int x0, input int y0,
                                  output int first, output bit any);
        any   = 0;
        first = 0;
        for (int k = 0; k < 16; k++) begin
            int  x, y;
            bit  hit;
            x = x0 + (k % 4);
            y = y0 + (k / 4);
            if (!b[k])                 hit = 0;
            else if (x >= 20 || y >= 20) hit = 1;
            else                         hit = f[y * 20 + x];
            if (hit && !any) begin
                any   = 1;
                first = k;
            end
        end
    endfunction

    function automatic int exp_trace(input int x0, input int y0, input int k);
        int x, y, fi;
        x  = x0 + (k % 4);
        y  = y0 + (k / 4);
        fi = (x >= 20 || y >= 20) ? 0 : y * 20 + x;
        return ((k % 4) << 15) | ((k / 4) << 13) | (k << 9) | fi;
    endfunction

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_e"}, {e_busy, e_done, e_collide, e_hit, e_bx, e_by, e_bi, e_fi}, 0);
        chk({tag, "_f"}, {f_busy, f_done, f_collide, f_hit, f_bx, f_by, f_bi, f_fi}, 0);
    endtask

    task automatic run_scan(input string tag, input logic [15:0] b, input logic [399:0] f,
                            input logic [4:0] x, input logic [4:0] y, input bit glitch);
        int first;
        bit any;
        int e_cyc = 0, f_cyc = 0, e_cnt = 0, f_cnt = 0;
        model(b, f, int'(x), int'(y), first, any);
        @(negedge clk);
        blk = b; fld = f; px = x; py = y; start = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                blk   = 16'($urandom);
                fld   = rand_field(50);
                px    = 5'($urandom);
                py    = 5'($urandom);
            end
            if (glitch && c == 5) start = 1'b1;
            if (glitch && c == 6) start = 1'b0;
            if (e_done) begin e_cnt++; e_cyc = c; end
            if (f_done) begin f_cnt++; f_cyc = c; end
            if (c <= 16)
                chk({tag, "_trace"}, {f_bx, f_by, f_bi, f_fi}, exp_trace(int'(x), int'(y), c - 1));
            chk({tag, "_busy_f"}, f_busy, 1);
        end
        chk({tag, "_done_cyc_e"}, e_cyc, any ? first + 2 : 17);
        chk({tag, "_done_cnt_e"}, e_cnt, 1);
        chk({tag, "_done_cyc_f"}, f_cyc, 17);
        chk({tag, "_done_cnt_f"}, f_cnt, 1);
        chk({tag, "_collide_e"}, e_collide, any);
        chk({tag, "_collide_f"}, f_collide, any);
        chk({tag, "_hit_e"}, e_hit, any ? first : 0);
        chk({tag, "_hit_f"}, f_hit, any ? first : 0);
    endtask

    initial begin
        logic [399:0] tf;
        rst_n = 1'b0;
        start = 1'b0;
        blk   = 16'h0;
        fld   = '0;
        px    = 5'd0;
        py    = 5'd0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset_state");
        rst_n = 1'b1;

        run_scan("empty", 16'h0000, rand_field(40), 5'd0, 5'd0, 1'b0);

        tf = '0;
        tf[103] = 1'b1;
        run_scan("overlap", 16'h0001, tf, 5'd3, 5'd5, 1'b0);

        run_scan("right_oob", 16'h8000, '0, 5'd17, 5'd0, 1'b0);
        run_scan("bottom_ok", 16'hF000, '0, 5'd16, 5'd16, 1'b0);

        tf = '0;
        tf[2]  = 1'b1;
        tf[41] = 1'b1;
        run_scan("order", 16'h0204, tf, 5'd0, 5'd0, 1'b0);

        run_scan("pos_x_far", 16'h0010, '0, 5'd25, 5'd0, 1'b0);
        run_scan("pos_y_far", 16'h8421, '0, 5'd2, 5'd31, 1'b0);
        run_scan("corner", 16'hFFFF, '0, 5'd19, 5'd19, 1'b0);

        for (int i = 0; i < 24; i++)
            run_scan("rand", 16'($urandom), rand_field($urandom_range(2, 30)),
                     5'($urandom_range(0, 21)), 5'($urandom_range(0, 21)), 1'b0);

        run_scan("glitch", 16'($urandom), '0, 5'd0, 5'd0, 1'b1);

        // Reset in the middle of a scan that has already flagged a collision.
        @(negedge clk);
        blk = 16'h0001; fld = '0; px = 5'd25; py = 5'd0; start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 7) chk("pre_rst_collide_f", f_collide, 1);
        end
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("mid_reset");
        repeat (2) @(negedge clk);
        chk_zero_outputs("held_reset");
        rst_n = 1'b1;

        tf = '0;
        tf[20 * 10 + 7] = 1'b1;
        run_scan("after_rst", 16'h0100, tf, 5'd7, 5'd8, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
